// File: rtl/lcd_video_out.sv
// LCD output stage: pixel-clock divider, raster/sync timing re-aligned to a
// pipelined pixel source, text-overlay colour compositing and PWM backlight.
module lcd_video_out #(
    parameter int CLOCK_DIVIDE = 2,
    parameter int H_ACTIVE     = 800,
    parameter int H_FRONT      = 40,
    parameter int H_SYNC       = 48,
    parameter int H_BACK       = 88,
    parameter int V_ACTIVE     = 480,
    parameter int V_FRONT      = 13,
    parameter int V_SYNC       = 3,
    parameter int V_BACK       = 32,
    parameter int COORD_BITS   = 11,
    parameter int COLOR_BITS   = 8,
    parameter int PIPE_DELAY   = 1,
    parameter int PWM_BITS     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  display_enable,
    input  logic [COLOR_BITS-1:0] pixel_red,
    input  logic [COLOR_BITS-1:0] pixel_green,
    input  logic [COLOR_BITS-1:0] pixel_blue,
    input  logic                  overlay_on,
    input  logic [PWM_BITS-1:0]   backlight_level,
    output logic                  tick,
    output logic [COORD_BITS-1:0] x,
    output logic [COORD_BITS-1:0] y,
    output logic                  active,
    output logic                  next_frame,
    output logic                  lcd_clock,
    output logic                  lcd_hs_n,
    output logic                  lcd_vs_n,
    output logic                  lcd_de,
    output logic [COLOR_BITS-1:0] lcd_red,
    output logic [COLOR_BITS-1:0] lcd_green,
    output logic [COLOR_BITS-1:0] lcd_blue,
    output logic                  lcd_display_on,
    output logic                  lcd_backlight_pwm
);
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_BITS = (CLOCK_DIVIDE >= 2) ? $clog2(CLOCK_DIVIDE) : 1;

    localparam logic [DIV_BITS-1:0]   DIV_LAST = DIV_BITS'(CLOCK_DIVIDE - 1);
    localparam logic [DIV_BITS-1:0]   DIV_HALF = DIV_BITS'(CLOCK_DIVIDE / 2);
    localparam logic [COORD_BITS-1:0] H_LAST   = COORD_BITS'(H_TOTAL - 1);
    localparam logic [COORD_BITS-1:0] V_LAST   = COORD_BITS'(V_TOTAL - 1);
    localparam logic [COORD_BITS-1:0] H_VIS    = COORD_BITS'(H_ACTIVE);
    localparam logic [COORD_BITS-1:0] V_VIS    = COORD_BITS'(V_ACTIVE);
    localparam logic [COORD_BITS-1:0] HS_BEGIN = COORD_BITS'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_BITS-1:0] HS_END   = COORD_BITS'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_BITS-1:0] VS_BEGIN = COORD_BITS'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_BITS-1:0] VS_END   = COORD_BITS'(V_ACTIVE + V_FRONT + V_SYNC);

    if (CLOCK_DIVIDE < 2) begin : g_bad_divide
        $error("lcd_video_out: CLOCK_DIVIDE must be >= 2");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("lcd_video_out: PIPE_DELAY must be in 0..7");
    end
    if ((H_TOTAL > (1 << COORD_BITS)) || (V_TOTAL > (1 << COORD_BITS))) begin : g_bad_coord
        $error("lcd_video_out: COORD_BITS too small for the raster totals");
    end

    logic [DIV_BITS-1:0]   div_q, div_d;
    logic                  tick_q, lcd_clock_q;
    logic [COORD_BITS-1:0] h_q, h_d, v_q, v_d;
    logic [PWM_BITS-1:0]   pwm_count_q, level_q, level_d;
    logic                  pwm_q, pwm_d;
    logic [2:0]            sync_now, sync_dly;   // {hs, vs, de}, active high
    logic                  hs_n_q, vs_n_q, de_q, display_on_q;
    logic [COLOR_BITS-1:0] red_q, green_q, blue_q, red_d, green_d, blue_d;

    assign active   = (h_q < H_VIS) && (v_q < V_VIS);
    assign sync_now = {(h_q >= HS_BEGIN) && (h_q < HS_END),
                       (v_q >= VS_BEGIN) && (v_q < VS_END),
                       active};

    // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        level_d = level_q;
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (pwm_count_q == '1) begin
                level_d = backlight_level;
            end
        end
        pwm_d = (level_q == '1) || (pwm_count_q < level_q);

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (sync_dly[0] && display_enable) begin
            if (overlay_on) begin
                red_d   = '1;
                green_d = '1;
                blue_d  = '1;
            end else begin
                red_d   = pixel_red;
                green_d = pixel_green;
                blue_d  = pixel_blue;
            end
        end
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign sync_dly = sync_now;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE_DELAY];
        // NOTE: the delay line is reset explicitly so stale pre-reset syncs never reach the pins.
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= 3'b000;
            end else if (tick_q) begin
                pipe_q[0] <= sync_now;
                for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign sync_dly = pipe_q[PIPE_DELAY-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q        <= '0;
            tick_q       <= 1'b0;
            lcd_clock_q  <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            pwm_count_q  <= '0;
            level_q      <= '0;
            pwm_q        <= 1'b0;
            display_on_q <= 1'b0;
            hs_n_q       <= 1'b1;
            vs_n_q       <= 1'b1;
            de_q         <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            div_q        <= div_d;
            tick_q       <= (div_q == DIV_LAST);
            // lcd_clock lags div by one clock, so it falls exactly as panel outputs update.
            lcd_clock_q  <= (div_q >= DIV_HALF);
            h_q          <= h_d;
            v_q          <= v_d;
            level_q      <= level_d;
            pwm_q        <= pwm_d;
            display_on_q <= display_enable;
            if (tick_q) begin
                pwm_count_q <= pwm_count_q + 1'b1;
                hs_n_q      <= ~sync_dly[2];
                vs_n_q      <= ~sync_dly[1];
                de_q        <= sync_dly[0];
                red_q       <= red_d;
                green_q     <= green_d;
                blue_q      <= blue_d;
            end
        end
    end

    assign tick              = tick_q;
    assign x                 = h_q;
    assign y                 = v_q;
    assign next_frame        = tick_q && (h_q == H_LAST) && (v_q == V_LAST);
    assign lcd_clock         = lcd_clock_q;
    assign lcd_hs_n          = hs_n_q;
    assign lcd_vs_n          = vs_n_q;
    assign lcd_de            = de_q;
    assign lcd_red           = red_q;
    assign lcd_green         = green_q;
    assign lcd_blue          = blue_q;
    assign lcd_display_on    = display_on_q;
    assign lcd_backlight_pwm = pwm_q;
endmodule

// File: tb/tb_lcd_video_out.sv
// Self-checking bench for lcd_video_out: two small-raster instances (divide 4 /
// delay 2 and divide 2 / delay 0) compared every clock against an arithmetic model.
`timescale 1ns/1ps
module tb_lcd_video_out;
    localparam int HA = 16, HF = 3, HS = 4, HB = 5;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VT = VA + VF + VS + VB;   // 12
    localparam int FRAME = HT * VT;          // 336
    localparam int DIV_A = 4, PD_A = 2, DIV_B = 2, PD_B = 0;

    logic       clock = 1'b0, reset = 1'b1, display_enable = 1'b0, overlay_on = 1'b0;
    logic [7:0] pixel_red = '0, pixel_green = '0, pixel_blue = '0;
    logic [3:0] backlight_level = '0;

    logic       tick_a, active_a, nf_a, lclk_a, hsn_a, vsn_a, de_a, don_a, pwm_a;
    logic [5:0] x_a, y_a;
    logic [7:0] r_a, g_a, b_a;
    logic       tick_b, active_b, nf_b, lclk_b, hsn_b, vsn_b, de_b, don_b, pwm_b;
    logic [5:0] x_b, y_b;
    logic [7:0] r_b, g_b, b_b;

    lcd_video_out #(.CLOCK_DIVIDE(DIV_A), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .COORD_BITS(6), .COLOR_BITS(8),
        .PIPE_DELAY(PD_A), .PWM_BITS(4)) u_dut_a (
        .clock(clock), .reset(reset), .display_enable(display_enable),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .overlay_on(overlay_on), .backlight_level(backlight_level),
        .tick(tick_a), .x(x_a), .y(y_a), .active(active_a), .next_frame(nf_a),
        .lcd_clock(lclk_a), .lcd_hs_n(hsn_a), .lcd_vs_n(vsn_a), .lcd_de(de_a),
        .lcd_red(r_a), .lcd_green(g_a), .lcd_blue(b_a),
        .lcd_display_on(don_a), .lcd_backlight_pwm(pwm_a));

    lcd_video_out #(.CLOCK_DIVIDE(DIV_B), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .COORD_BITS(6), .COLOR_BITS(8),
        .PIPE_DELAY(PD_B), .PWM_BITS(4)) u_dut_b (
        .clock(clock), .reset(reset), .display_enable(display_enable),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .overlay_on(overlay_on), .backlight_level(backlight_level),
        .tick(tick_b), .x(x_b), .y(y_b), .active(active_b), .next_frame(nf_b),
        .lcd_clock(lclk_b), .lcd_hs_n(hsn_b), .lcd_vs_n(vsn_b), .lcd_de(de_b),
        .lcd_red(r_b), .lcd_green(g_b), .lcd_blue(b_b),
        .lcd_display_on(don_b), .lcd_backlight_pwm(pwm_b));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: clocks since reset, latched PWM level, inputs seen at the last tick.
    int          e_m [2]      = '{0, 0};
    int          lvl_m [2]    = '{0, 0};
    int          prev_t [2]   = '{0, 0};
    int          prev_lvl [2] = '{0, 0};
    logic [23:0] tick_pix [2] = '{24'h0, 24'h0};
    logic        tick_ovl [2] = '{1'b0, 1'b0};
    logic        tick_den [2] = '{1'b0, 1'b0};
    logic        den_edge     = 1'b0;

    int          mode = 0, rst_cycles = 0;
    logic        den_req = 1'b0;
    logic [3:0]  bl_req = '0;
    logic [26:0] pan_a_prev, pan_b_prev;
    int          b_ticks = 0, b_frames = 0;

    function automatic int div_of(input int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction
    function automatic int pd_of(input int k);
        return (k == 0) ? PD_A : PD_B;
    endfunction
    // Number of pixel ticks already applied to the raster after e clocks out of reset.
    function automatic int ticks_of(input int e, input int d);
        return (e >= 1) ? (e - 1) / d : 0;
    endfunction
    function automatic bit tick_of(input int e, input int d);
        return (e >= 1) && (e % d == 0);
    endfunction
    function automatic bit pwm_of(input int t, input int l);
        return (l == 15) || ((t % 16) < l);
    endfunction

    task automatic check_inst(input int k, input string nm, input logic tk, input logic [5:0] ox,
                              input logic [5:0] oy, input logic act, input logic nf, input logic lclk,
                              input logic hsn, input logic vsn, input logic de,
                              input logic [23:0] rgb, input logic don, input logic pwm);
        int d, p, e, t, ex, ey, idx, hx, vy;
        bit etick, ehs, evs, ede;
        logic [23:0] ergb;
        d = div_of(k);
        p = pd_of(k);
        e = e_m[k];
        t = ticks_of(e, d);
        etick = tick_of(e, d);
        ex = t % HT;
        ey = (t / HT) % VT;
        check({nm, ".tick"}, tk, etick);
        check({nm, ".xy"}, {ox, oy}, {6'(ex), 6'(ey)});
        check({nm, ".act_nf_clk"}, {act, nf, lclk},
              {(ex < HA) && (ey < VA), etick && (t % FRAME == FRAME - 1),
               (e >= 1) && (((e - 1) % d) >= d / 2)});
        ehs = 1'b0; evs = 1'b0; ede = 1'b0;
        idx = t - 1 - p;
        if (t >= 1 && idx >= 0) begin
            hx  = idx % HT;
            vy  = (idx / HT) % VT;
            ehs = (hx >= HA + HF) && (hx < HA + HF + HS);
            evs = (vy >= VA + VF) && (vy < VA + VF + VS);
            ede = (hx < HA) && (vy < VA);
        end
        check({nm, ".sync"}, {hsn, vsn, de}, {!ehs, !evs, ede});
        ergb = 24'h0;
        if (t >= 1 && ede && tick_den[k]) ergb = tick_ovl[k] ? 24'hFFFFFF : tick_pix[k];
        check({nm, ".rgb"}, rgb, ergb);
        check({nm, ".don_pwm"}, {don, pwm}, {den_edge, (e >= 1) && pwm_of(prev_t[k], prev_lvl[k])});
    endtask

    task automatic drive();
        int j;
        reset = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        overlay_on = 1'b0;
        case (mode)
            1: begin
                pixel_red   = 8'($urandom);
                pixel_green = 8'($urandom);
                pixel_blue  = 8'($urandom);
                overlay_on  = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 99) < 3) display_enable = ~display_enable;
                if ($urandom_range(0, 49) == 0) backlight_level = 4'($urandom);
            end
            2: begin
                {pixel_red, pixel_green, pixel_blue} = 24'h123456;
                display_enable = 1'b1;
                j = ticks_of(e_m[0], DIV_A) - PD_A;
                overlay_on = tick_of(e_m[0], DIV_A) && (j >= 0) && (j % HT == 10);
            end
            default: begin
                display_enable  = den_req;
                backlight_level = bl_req;
            end
        endcase
    endtask

    task automatic model_edge();
        int d;
        for (int k = 0; k < 2; k++) begin
            d = div_of(k);
            if (reset) begin
                e_m[k] = 0; lvl_m[k] = 0; prev_t[k] = 0; prev_lvl[k] = 0;
            end else begin
                prev_t[k]   = ticks_of(e_m[k], d);
                prev_lvl[k] = lvl_m[k];
                if (tick_of(e_m[k], d)) begin
                    tick_pix[k] = {pixel_red, pixel_green, pixel_blue};
                    tick_ovl[k] = overlay_on;
                    tick_den[k] = display_enable;
                    if (ticks_of(e_m[k], d) % 16 == 15) lvl_m[k] = int'(backlight_level);
                end
                e_m[k]++;
            end
        end
        den_edge = reset ? 1'b0 : display_enable;
    endtask

    task automatic step();
        logic [26:0] pan_a, pan_b;
        @(negedge clock);
        check_inst(0, "A", tick_a, x_a, y_a, active_a, nf_a, lclk_a, hsn_a, vsn_a, de_a,
                   {r_a, g_a, b_a}, don_a, pwm_a);
        check_inst(1, "B", tick_b, x_b, y_b, active_b, nf_b, lclk_b, hsn_b, vsn_b, de_b,
                   {r_b, g_b, b_b}, don_b, pwm_b);
        pan_a = {hsn_a, vsn_a, de_a, r_a, g_a, b_a};
        pan_b = {hsn_b, vsn_b, de_b, r_b, g_b, b_b};
        if (pan_a != pan_a_prev) check("A.change_in_low_half", lclk_a, 1'b0);
        if (pan_b != pan_b_prev) check("B.change_in_low_half", lclk_b, 1'b0);
        pan_a_prev = pan_a;
        pan_b_prev = pan_b;
        if (e_m[1] == 0) begin
            b_ticks = 0; b_frames = 0;
        end else begin
            if (tick_b) b_ticks++;
            if (nf_b) begin
                b_frames++;
                check("B.frame_len", b_ticks, b_frames * FRAME);
            end
        end
        drive();
        model_edge();
    endtask

    task automatic duty_test(input logic [3:0] lv);
        int hi_a, hi_b, exp_duty;
        bl_req = lv;
        mode   = 0;
        repeat (40 * DIV_A) step();
        hi_a = 0; hi_b = 0;
        for (int i = 0; i < 16 * DIV_A; i++) begin
            step();
            hi_a += int'(pwm_a);
            if (i < 16 * DIV_B) hi_b += int'(pwm_b);
        end
        exp_duty = (lv == 4'hF) ? 16 : int'(lv);
        check("A.duty", hi_a, DIV_A * exp_duty);
        check("B.duty", hi_b, DIV_B * exp_duty);
    endtask

    initial begin
        int ff_cnt, de_cnt, hs_cnt, vs_cnt, guard;

        rst_cycles = 5;
        repeat (6) step();
        check("reset.hs_vs_de", {hsn_a, vsn_a, de_a}, 3'b110);
        check("reset.xy", {x_a, y_a, x_b, y_b}, 24'h0);
        check("reset.misc", {tick_a, nf_a, lclk_a, don_a, pwm_a, r_a, g_a, b_a}, 29'h0);

        // Random pixels, overlay, display gating and backlight changes (including mid-period).
        mode = 1;
        repeat (2 * FRAME * DIV_A) step();

        // Overlay lit exactly for the pixel source's x == 10 on every line.
        mode = 2;
        repeat (40) step();
        ff_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < FRAME * DIV_A; i++) begin
            step();
            if ({r_a, g_a, b_a} == 24'hFFFFFF) ff_cnt++;
            if (de_a) de_cnt++;
            if (!hsn_a) hs_cnt++;
            if (!vsn_a) vs_cnt++;
        end
        check("A.overlay_pixels", ff_cnt, VA * DIV_A);
        check("A.de_per_frame", de_cnt, HA * VA * DIV_A);
        check("A.hs_per_frame", hs_cnt, HS * VT * DIV_A);
        check("A.vs_per_frame", vs_cnt, VS * HT * DIV_A);

        duty_test(4'd0);
        duty_test(4'd8);
        duty_test(4'd15);

        // Reset mid-frame while the delay line holds active data.
        mode = 0;
        den_req = 1'b1;
        guard = 0;
        while (!((ticks_of(e_m[0], DIV_A) % HT == 10) && ((ticks_of(e_m[0], DIV_A) / HT) % VT == 3))
               && guard < 3000) begin
            step();
            guard++;
        end
        check("wait_mid_frame", guard < 3000, 1'b1);
        rst_cycles = 1;
        step();
        step();
        check("midreset.xy", {x_a, y_a}, 12'h0);
        check("midreset.sync", {hsn_a, vsn_a, de_a, r_a, g_a, b_a}, {3'b110, 24'h0});
        repeat (30 * DIV_A) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_video_out.md
Name: lcd_video_out

Overview:
Parametrised LCD output stage driving a parallel RGB panel from one system clock.
- Generates the pixel clock/tick, raster counters and sync/data-enable timing.
- Composites a 1-bit text overlay over pixel-source colour, with blanking and display-on gating.
- Drives a PWM backlight.
- Re-aligns sync/DE to a pixel source of configurable latency.
- Sits between the frame buffer / text font path and the GPIO pins.

Parameters:
CLOCK_DIVIDE, 2, system clocks per pixel; must be >= 2.
H_ACTIVE, 800, visible pixels per line.
H_FRONT, 40, horizontal front porch, in pixels.
H_SYNC, 48, hsync width, in pixels.
H_BACK, 88, horizontal back porch, in pixels.
V_ACTIVE, 480, visible lines.
V_FRONT, 13, vertical front porch, in lines.
V_SYNC, 3, vsync width, in lines.
V_BACK, 32, vertical back porch, in lines.
COORD_BITS, 11, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1.
COLOR_BITS, 8, bits per colour channel.
PIPE_DELAY, 1, pixel ticks from x/y out to matching pixel_* in; 0..7.
PWM_BITS, 8, backlight PWM resolution.

Ports:
clock  in  1  system clock (50 MHz).
reset  in  1  synchronous, active-high reset.
display_enable  in  1  panel on; when low, colours are forced to 0 and timing keeps running.
pixel_red  in  COLOR_BITS  source red for the pixel requested PIPE_DELAY ticks earlier.
pixel_green  in  COLOR_BITS  source green, same timing as pixel_red.
pixel_blue  in  COLOR_BITS  source blue, same timing as pixel_red.
overlay_on  in  1  text pixel lit, same timing as pixel_*; forces white.
backlight_level  in  PWM_BITS  PWM duty; all-ones means constant on.
tick  out  1  one-clock pulse per pixel.
x  out  COORD_BITS  current horizontal raster position.
y  out  COORD_BITS  current vertical raster position.
active  out  1  x < H_ACTIVE and y < V_ACTIVE (undelayed).
next_frame  out  1  one-clock pulse on the tick that wraps the raster to (0,0).
lcd_clock  out  1  pixel clock to panel.
lcd_hs_n  out  1  hsync, active low, aligned with colour.
lcd_vs_n  out  1  vsync, active low, aligned with colour.
lcd_de  out  1  data enable, aligned with colour.
lcd_red  out  COLOR_BITS  registered panel colour.
lcd_green  out  COLOR_BITS  registered panel colour.
lcd_blue  out  COLOR_BITS  registered panel colour.
lcd_display_on  out  1  registered copy of display_enable.
lcd_backlight_pwm  out  1  registered backlight PWM.

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (976 by default); V_TOTAL likewise (528 by default).
- Reset values: all counters 0. tick=0, next_frame=0, lcd_clock=0, lcd_hs_n=1, lcd_vs_n=1, lcd_de=0, colours 0, lcd_display_on=0, lcd_backlight_pwm=0. Delay line is filled with inactive values (hs_n=1, vs_n=1, de=0). Reset mid-frame restarts the raster at (0,0) on the next clock.
- Divider: div counts 0..CLOCK_DIVIDE-1 and wraps. tick is registered and high for exactly the cycle after div==CLOCK_DIVIDE-1.
- Pixel clock: lcd_clock is registered; low while div < CLOCK_DIVIDE/2 (integer division), high otherwise. For CLOCK_DIVIDE=2 it toggles every clock.
- Panel outputs change only on tick cycles, i.e. while lcd_clock is low, so the panel samples on the rising edge.
- Raster: on tick, h increments. At h==H_TOTAL-1, h wraps to 0 and v increments. At v==V_TOTAL-1 with h wrapping, v wraps to 0. x=h and y=v are combinational from the counter registers.
- next_frame is high on the tick where h==H_TOTAL-1 and v==V_TOTAL-1.
- Undelayed sync:
  - hs = (H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC).
  - vs = (V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC); vs changes at h==0.
  - de = active.
- Alignment: {hs, vs, de} pass through a PIPE_DELAY-stage shift register that advances on tick only (PIPE_DELAY=0 means a straight wire). The shift register stage is then registered with colour on the same tick, so total output latency from x/y to pins is PIPE_DELAY+1 ticks.
- Colour select, registered on tick:
  - delayed de=0, or display_enable=0 -> 0.
  - else overlay_on=1 -> all ones.
  - else pixel_*.
- lcd_display_on <= display_enable on every clock.
- PWM: pwm_count (PWM_BITS) increments on tick and wraps. backlight_level is latched into level_q when pwm_count wraps to 0, so a mid-period change takes effect on the next period.
- lcd_backlight_pwm = (pwm_count < level_q), or 1 if level_q is all ones. Level 0 gives constant 0.
- No-simultaneity issue: all counters advance on the same tick.
- Parameter checks: CLOCK_DIVIDE<2 or PIPE_DELAY>7 is an elaboration error.

Test Plan:
1. Defaults, release reset: tick every 2nd clock; lcd_clock toggles each clock; first next_frame after exactly 976*528=515328 ticks, then every 515328 ticks.
2. CLOCK_DIVIDE=4: tick every 4 clocks; lcd_clock 2 low / 2 high, with colour changes only in the low half.
3. Defaults, PIPE_DELAY=1: lcd_hs_n low for 48 ticks starting 2 ticks after x=840. lcd_vs_n low for lines 493..495 (delayed 2 ticks). lcd_de high for 800 ticks per line on lines 0..479.
4. pixel=0x123456, overlay toggled at x=10, PIPE_DELAY=2: panel shows FFFFFF exactly at the tick with de for x=10. Colour is 0 whenever lcd_de=0 or display_enable=0.
5. backlight_level 0 / 128 / 255: duty over 256 ticks is 0 / 128 / 256. A level changed mid-period takes effect only after wrap.
6. Assert reset at x=400, y=200 for one clock: next cycle x=y=0, outputs at reset values, and the delay line is inactive for PIPE_DELAY+1 ticks.
